ula_seq: RTL

//  Parametrised, handshaked successor to the 16-bit combinational ULA, with the same 4-bit opcode map.

---
 rtl/ula_pkg.sv | 26 ++
 rtl/ula_iter_muldiv.sv | 92 +++++++++
 rtl/ula_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the sequential ULA.
//   - 4-bit opcode constants (OP_AND .. OP_LE). Codes 4'hD..4'hF are illegal.
//   - FSM state type used by ula_seq.
package ula_pkg;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_NAND = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_INC  = 4'h7;
    localparam logic [3:0] OP_MUL  = 4'h8;
    localparam logic [3:0] OP_DIV  = 4'h9;
    localparam logic [3:0] OP_EQ   = 4'hA;
    localparam logic [3:0] OP_GE   = 4'hB;
    localparam logic [3:0] OP_LE   = 4'hC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ula_iter_muldiv.sv
// ula_iter_muldiv: iterative unsigned multiplier / divider, one bit per cycle.
//   MUL: LSB-first shift-add. {hi,lo} starts as {0,a}; each step adds b into
//        hi when lo[0] is set, then shifts {carry,hi,lo} right by one.
//   DIV: restoring division. {hi,lo} starts as {0,a}; each step shifts the
//        next dividend bit into hi, subtracts b if it fits, and shifts the
//        quotient bit into lo.
//   After WIDTH steps: MUL {hi,lo} = a*b; DIV lo = a/b, hi = a%b.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        load operands (one-cycle pulse); first step happens next cycle
//   is_div       1 = divide, 0 = multiply (sampled with start)
//   a, b         operands (sampled with start)
//   done         high during the cycle in which the final step is performed
//   lo, hi       result registers, held until the next start
module ula_iter_muldiv
    import ula_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             busy_q;
    logic             is_div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    always_comb begin
        // Shift-add step; the carry of the add becomes the new hi MSB.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        // Restoring step. The partial remainder is always < b, so after the
        // shift it is < 2b and the difference (when taken) fits in WIDTH bits.
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_diff  = div_shift[WIDTH-1:0] - b_q;

        if (is_div_q) begin
            hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            b_q      <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            is_div_q <= is_div;
            cnt_q    <= CNT_W'(WIDTH - 1);
            b_q      <= b;
            lo_q     <= a;
            hi_q     <= '0;
        end else if (busy_q) begin
            lo_q  <= lo_d;
            hi_q  <= hi_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done = busy_q && (cnt_q == '0);
    assign lo   = lo_q;
    assign hi   = hi_q;

endmodule

// File: rtl/ula_seq.sv
// ula_seq: handshaked, registered ULA with iterative MUL/DIV.
//   Single-cycle ops are computed from the inputs and registered on the
//   accept edge. MUL/DIV (b!=0 for DIV) run in ula_iter_muldiv; in DONE the
//   outputs are taken straight from its result registers.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   op, a, b              opcode and unsigned operands, captured on accept
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   result, result_hi     low / high result words
//   flag_z, flag_c, flag_v, flag_dz, flag_err   status flags
module ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_dz,
    output logic             flag_err
);

    state_t state_q, state_d;

    logic             accept;
    logic             iter_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_lo, iter_hi;

    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [WIDTH-1:0] res_c, hi_c;
    logic             c_c, v_c, dz_c, err_c, go_iter;

    logic [WIDTH-1:0] result_q, result_hi_q;
    logic             z_q, c_q, v_q, dz_q, err_q;
    logic             iter_sel_q;   // outputs come from the iterative unit
    logic             is_mul_q;

    // Single-cycle datapath and flags, from the live inputs.
    always_comb begin
        sum_ext  = {1'b0, a} + {1'b0, b};
        diff_ext = {1'b0, a} - {1'b0, b};   // MSB is the borrow (a < b)
        res_c    = '0;
        hi_c     = '0;
        c_c      = 1'b0;
        v_c      = 1'b0;
        dz_c     = 1'b0;
        err_c    = 1'b0;
        go_iter  = 1'b0;
        case (op)
            OP_AND:  res_c = a & b;
            OP_OR:   res_c = a | b;
            OP_XOR:  res_c = a ^ b;
            OP_NAND: res_c = ~(a & b);
            OP_NOR:  res_c = ~(a | b);
            OP_ADD: begin
                res_c = sum_ext[WIDTH-1:0];
                c_c   = sum_ext[WIDTH];
                v_c   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_c = diff_ext[WIDTH-1:0];
                c_c   = diff_ext[WIDTH];
                v_c   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_INC: begin
                res_c = a + WIDTH'(1);
                c_c   = &a;
            end
            OP_MUL:  go_iter = 1'b1;
            OP_DIV: begin
                if (b == '0) begin
                    res_c = '1;
                    hi_c  = a;
                    dz_c  = 1'b1;
                end else begin
                    go_iter = 1'b1;
                end
            end
            OP_EQ:   res_c = WIDTH'(a == b);
            OP_GE:   res_c = WIDTH'(a >= b);
            OP_LE:   res_c = WIDTH'(a <= b);
            default: err_c = 1'b1;   // 4'hD..4'hF
        endcase
    end

    assign accept     = in_valid && (state_q == IDLE);
    assign iter_start = accept && go_iter;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = go_iter ? BUSY : DONE;
            BUSY:    if (iter_done) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            dz_q        <= 1'b0;
            err_q       <= 1'b0;
            iter_sel_q  <= 1'b0;
            is_mul_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                result_q    <= res_c;
                result_hi_q <= hi_c;
                z_q         <= (res_c == '0);
                c_q         <= c_c;
                v_q         <= v_c;
                dz_q        <= dz_c;
                err_q       <= err_c;
                iter_sel_q  <= go_iter;
                is_mul_q    <= (op == OP_MUL);
            end
        end
    end

    ula_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start),
        .is_div (op == OP_DIV),
        .a      (a),
        .b      (b),
        .done   (iter_done),
        .lo     (iter_lo),
        .hi     (iter_hi)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = iter_sel_q ? iter_lo : result_q;
    assign result_hi = iter_sel_q ? iter_hi : result_hi_q;
    assign flag_z    = iter_sel_q ? (iter_lo == '0) : z_q;
    assign flag_v    = iter_sel_q ? (is_mul_q && (iter_hi != '0)) : v_q;
    assign flag_c    = c_q;
    assign flag_dz   = dz_q;
    assign flag_err  = err_q;

endmodule
